outputc: RTL and testbench

OUTPUTC -- requirements
Module: outputc

---
 rtl/outputc.sv | 157 +++++++++++++++
 tb/tb_outputc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/outputc.sv
// Router output-port controller: round-robin arbitration over five input
// channels, wormhole lock until a tail flit, registered flit output and a
// sticky protocol-error flag.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 30
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b00
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module outputc #(
  parameter int PORTID   = 0,
  parameter int ROUTERID = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req_0, req_1, req_2, req_3, req_4,
  input  logic [`PORTW:0]   port_0, port_1, port_2, port_3, port_4,
  input  logic [`DATAW:0]   idata_0, idata_1, idata_2, idata_3, idata_4,
  input  logic              ivalid_0, ivalid_1, ivalid_2, ivalid_3, ivalid_4,
  input  logic              irdy,
  output logic              grt_0, grt_1, grt_2, grt_3, grt_4,
  output logic [`DATAW:0]   odata,
  output logic              ovalid,
  output logic [`VCHW:0]    ovch,
  output logic              olck,
  output logic              err
);
  localparam int NUM_IN = 5;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [2:0]        owner, last, sel;
  logic              found;
  logic [NUM_IN-1:0] req, ivalid, cand, grt;
  logic [`PORTW:0]   port  [NUM_IN];
  logic [`DATAW:0]   idata [NUM_IN];
  logic [`DATAW:0]   own_data;
  logic              own_vld;
  logic [1:0]        own_type;
  logic              accept, acc_tail, acc_head, mid;
  logic              unused_rid;

  // ROUTERID is informational only
  assign unused_rid = (ROUTERID != 0);

  assign req    = {req_4, req_3, req_2, req_1, req_0};
  assign ivalid = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
  assign port[0]  = port_0;  assign port[1]  = port_1;  assign port[2]  = port_2;
  assign port[3]  = port_3;  assign port[4]  = port_4;
  assign idata[0] = idata_0; assign idata[1] = idata_1; assign idata[2] = idata_2;
  assign idata[3] = idata_3; assign idata[4] = idata_4;
  assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt;
  assign ovch = '0;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_cand
    assign cand[i] = req[i] && (port[i] == (`PORTW+1)'(PORTID));
  end

  // round-robin pick: first candidate after the last owner, wrapping mod 5
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      int idx;
      idx = int'(last) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  // owner's flit and valid, selected by the locked owner index
  always_comb begin
    own_data = '0;
    own_vld  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (owner == 3'(i)) begin
        own_data = idata[i];
        own_vld  = ivalid[i];
      end
    end
  end

  assign own_type = own_data[`TYPE_MSB:`TYPE_LSB];
  assign accept   = (state == LOCK) && own_vld && irdy;
  assign acc_tail = accept && (own_type == `TYPE_TAIL || own_type == `TYPE_HEADTAIL);
  assign acc_head = accept && (own_type == `TYPE_HEAD || own_type == `TYPE_HEADTAIL);

  // state register
  always_ff @(posedge clk) begin
    if (rst_) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state: lock on a winner, release only once a tail is accepted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found)    state_nxt = LOCK;
      LOCK: if (acc_tail) state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // outputs: grant follows irdy combinationally for the locked owner only
  always_comb begin
    grt  = '0;
    olck = (state == LOCK);
    for (int i = 0; i < NUM_IN; i++)
      grt[i] = (state == LOCK) && irdy && (owner == 3'(i));
  end

  // owner/pointer bookkeeping, output flit register and sticky error
  always_ff @(posedge clk) begin
    if (rst_) begin
      owner  <= '0;
      last   <= 3'd4;
      odata  <= '0;
      ovalid <= 1'b0;
      mid    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE && found) owner <= sel;
      if (acc_tail) last <= owner;
      ovalid <= accept;
      odata  <= accept ? own_data : '0;
      if (accept) mid <= !acc_tail;
      // flit offered without a grant, or a head arriving inside a packet
      if (|(ivalid & ~grt) || (acc_head && mid)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_outputc.sv
// Directed bench for outputc (PORTID=2): a scoreboard queue holds the flits
// expected on odata; a negedge monitor pops and compares them.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef VCHW
`define VCHW 0
`endif

module tb_outputc;
  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic              clk = 1'b0;
  logic              rst_;
  logic [4:0]        req, ivalid;
  logic [`PORTW:0]   port  [5];
  logic [`DATAW:0]   idata [5];
  logic              irdy;
  wire  [4:0]        grt;
  wire  [`DATAW:0]   odata;
  wire               ovalid, olck, err;
  wire  [`VCHW:0]    ovch;

  int n_assert = 0;
  int n_fail   = 0;
  logic [`DATAW:0] exp_q[$];

  outputc #(.PORTID(2), .ROUTERID(7)) dut (
    .clk(clk), .rst_(rst_),
    .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]), .req_4(req[4]),
    .port_0(port[0]), .port_1(port[1]), .port_2(port[2]), .port_3(port[3]), .port_4(port[4]),
    .idata_0(idata[0]), .idata_1(idata[1]), .idata_2(idata[2]), .idata_3(idata[3]), .idata_4(idata[4]),
    .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]), .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
    .irdy(irdy),
    .grt_0(grt[0]), .grt_1(grt[1]), .grt_2(grt[2]), .grt_3(grt[3]), .grt_4(grt[4]),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .olck(olck), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [`DATAW:0] flit(input logic [1:0] t, input logic [29:0] pl);
    return {t, pl};
  endfunction

  // advance one cycle; flit valids are single-cycle pulses by default
  task automatic cyc();
    @(posedge clk); #1;
    ivalid = '0;
  endtask

  task automatic send(input int i, input logic [1:0] t, input logic [29:0] pl, input bit expect_out);
    ivalid[i] = 1'b1;
    idata[i]  = flit(t, pl);
    if (expect_out) exp_q.push_back(flit(t, pl));
  endtask

  // output monitor: every valid flit must match the scoreboard head
  always @(negedge clk) begin
    if (ovalid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_flit", odata, 32'hdead_beef);
      else chk("odata", odata, exp_q.pop_front());
    end else begin
      chk("odata_idle", odata, 32'h0);
    end
  end

  initial begin
    // reset with garbage on the inputs: outputs must stay at reset values
    rst_ = 1'b1; irdy = 1'b1;
    req = 5'b11111; ivalid = 5'b00100;
    for (int i = 0; i < 5; i++) begin port[i] = 3'd2; idata[i] = 32'h1234_5678; end
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_grt", grt, 0); chk("rst_olck", olck, 0); chk("rst_ovalid", ovalid, 0);
    chk("rst_err", err, 0); chk("rst_ovch", ovch, 0);

    // inputs 0 and 3 target port 2; 0 wins first (last=4), then 3 after a bubble
    cyc(); rst_ = 1'b0; req = 5'b01001;
    for (int i = 0; i < 5; i++) port[i] = 3'd7;
    port[0] = 3'd2; port[3] = 3'd2;
    @(negedge clk); chk("t1_arb_grt", grt, 0); chk("t1_arb_olck", olck, 0);
    cyc(); send(0, T_HT, 30'h11, 1);
    @(negedge clk); chk("t1_grt0", grt, 5'b00001); chk("t1_olck", olck, 1);
    cyc(); req[0] = 1'b0;
    @(negedge clk); chk("t1_bubble_grt", grt, 0); chk("t1_bubble_olck", olck, 0);
    cyc(); send(3, T_HT, 30'h33, 1);
    @(negedge clk); chk("t1_grt3", grt, 5'b01000);
    cyc(); req[3] = 1'b0;

    // four-flit packet from input 1 while input 4 also requests
    port[1] = 3'd2; port[4] = 3'd2;
    cyc(); req[1] = 1'b1;
    cyc(); req[4] = 1'b1; send(1, T_HEAD, 30'h100, 1);
    @(negedge clk); chk("t2_head_grt", grt, 5'b00010);
    cyc(); send(1, T_BODY, 30'h101, 1);
    @(negedge clk); chk("t2_body1_grt", grt, 5'b00010);
    cyc(); send(1, T_BODY, 30'h102, 1);
    @(negedge clk); chk("t2_body2_grt", grt, 5'b00010);
    cyc(); send(1, T_TAIL, 30'h103, 1);
    @(negedge clk); chk("t2_tail_grt", grt, 5'b00010);
    cyc(); req[1] = 1'b0;
    @(negedge clk); chk("t2_bubble_grt", grt, 0);
    cyc(); send(4, T_HT, 30'h400, 1);
    @(negedge clk); chk("t2_grt4", grt, 5'b10000);
    cyc(); req[4] = 1'b0;

    // irdy stall for three cycles mid-packet
    cyc(); req[0] = 1'b1;
    cyc(); send(0, T_HEAD, 30'h200, 1);
    @(negedge clk); chk("t3_head_grt", grt, 5'b00001);
    for (int s = 0; s < 3; s++) begin
      cyc(); irdy = 1'b0;
      @(negedge clk); chk("t3_stall_grt", grt, 0); chk("t3_stall_olck", olck, 1);
      if (s > 0) chk("t3_stall_ovalid", ovalid, 0);
    end
    cyc(); irdy = 1'b1; send(0, T_BODY, 30'h201, 1);
    @(negedge clk); chk("t3_resume_grt", grt, 5'b00001);
    cyc(); send(0, T_TAIL, 30'h202, 1);
    cyc(); req[0] = 1'b0;
    @(negedge clk); chk("t3_err", err, 0);

    // ungranted valid on input 2: error, flit dropped, error is sticky
    cyc(); send(2, T_HT, 30'h3ff, 0);
    cyc();
    @(negedge clk); chk("t4_err", err, 1); chk("t4_ovalid", ovalid, 0);
    cyc(); cyc();
    @(negedge clk); chk("t4_err_hold", err, 1);

    // reset during a body flit aborts the packet; input 0 gets priority after
    cyc(); rst_ = 1'b1;
    cyc(); rst_ = 1'b0; req[3] = 1'b1;
    @(negedge clk); chk("t5_err_clr", err, 0);
    cyc(); send(3, T_HEAD, 30'h500, 1);
    @(negedge clk); chk("t5_grt3", grt, 5'b01000);
    cyc(); send(3, T_BODY, 30'h501, 0); rst_ = 1'b1;
    cyc(); rst_ = 1'b0; req[0] = 1'b1;
    @(negedge clk); chk("t5_olck", olck, 0); chk("t5_ovalid", ovalid, 0); chk("t5_grt", grt, 0);
    cyc(); send(0, T_HT, 30'h502, 1);
    @(negedge clk); chk("t5_grt0", grt, 5'b00001);
    cyc(); req[0] = 1'b0;
    @(negedge clk); chk("t5_bubble", grt, 0);
    cyc(); send(3, T_HT, 30'h503, 1);
    @(negedge clk); chk("t5_grt3b", grt, 5'b01000);
    cyc(); req[3] = 1'b0;

    // head arriving in the middle of a packet flags an error
    cyc(); req[1] = 1'b1;
    cyc(); send(1, T_HEAD, 30'h600, 1);
    @(negedge clk); chk("t6_grt1", grt, 5'b00010);
    cyc(); send(1, T_HEAD, 30'h601, 1);
    @(negedge clk); chk("t6_err_pre", err, 0);
    cyc(); send(1, T_TAIL, 30'h602, 1);
    @(negedge clk); chk("t6_err", err, 1);
    cyc(); req[1] = 1'b0;
    @(negedge clk); chk("t6_err_hold", err, 1); chk("t6_olck", olck, 0);

    // all five inputs contend: grant order 0,1,2,3,4,0
    cyc(); rst_ = 1'b1;
    cyc(); rst_ = 1'b0; req = 5'b11111;
    for (int i = 0; i < 5; i++) port[i] = 3'd2;
    for (int k = 0; k < 6; k++) begin
      int e;
      e = k % 5;
      @(negedge clk); chk("t7_arb_grt", grt, 0);
      cyc(); send(e, T_HT, 30'(32'h700 + k), 1);
      @(negedge clk); chk("t7_grt", grt, 32'(5'b00001 << e));
      cyc();
    end
    req = '0;

    cyc(); cyc(); cyc();
    @(negedge clk); chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
